// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/opcode request channel and result/flag response channel
// for the sequential ALU. The ALU takes the slave modport and the producer/consumer
// side takes the master modport.
interface alu_seq_if #(
  parameter int P = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] A;
  logic [P-1:0] B;
  logic [3:0]   OP;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] S;
  logic         N;
  logic         Z;
  logic         C;
  logic         V;
  logic         ERR;

  modport master (
    output in_valid, A, B, OP, out_ready,
    input  in_ready, out_valid, S, N, Z, C, V, ERR
  );

  modport slave (
    input  in_valid, A, B, OP, out_ready,
    output in_ready, out_valid, S, N, Z, C, V, ERR
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle P-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops (add/sub/shifts/logic) are registered straight into DONE.
// MUL runs an iterative shift-add unit and DIV/MOD run a restoring divider, each
// one bit per cycle for P cycles in EXEC.
// Optional feature: define ALU_SEQ_SRA_EN to make OP=10 an arithmetic shift
// right; without it OP=10 decodes as an illegal opcode.
module alu_seq #(
  parameter int P = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int CW = (P > 2) ? $clog2(P) : 1;
  localparam logic [CW-1:0] LAST = CW'(P - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [P:0] P_WIDE = (P + 1)'(P);
  localparam logic [P-1:0] LSB_ONE = {{(P-1){1'b0}}, 1'b1};
  localparam logic [P-1:0] MSB_ONE = {1'b1, {(P-1){1'b0}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SHR = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;

  typedef struct packed {
    logic [P-1:0] s;
    logic         c;
    logic         v;
    logic         err;
  } res_t;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [P-1:0]  a_reg;
  logic [P-1:0]  b_reg;
  logic [3:0]    op_reg;

  logic [P-1:0]  mul_hi;
  logic [P-1:0]  mul_lo;
  logic [P-1:0]  div_rem;
  logic [P-1:0]  div_q;
  logic [P-1:0]  mul_hi_next;
  logic [P-1:0]  mul_lo_next;
  logic [P-1:0]  div_rem_next;
  logic [P-1:0]  div_q_next;
  logic [P:0]    mul_sum;
  logic [P:0]    div_shift;

  logic          accept;
  logic          is_iter;
  logic          iter_done;
  logic          load_out;
  res_t          single_res;
  res_t          exec_res;
  res_t          out_next;

  logic [P-1:0]  s_reg;
  logic          n_reg;
  logic          z_reg;
  logic          c_reg;
  logic          v_reg;
  logic          err_reg;

  // Result of every op that completes in one cycle, including illegal opcodes.
  // Shifts by zero pass A through, shifts by P or more clear the carry.
  function automatic res_t single_op(input logic [P-1:0] a, input logic [P-1:0] b,
                                     input logic [3:0] op);
    res_t         r;
    logic [P:0]   wide;
    logic [P-1:0] mask;
    logic         big;
    r    = '0;
    wide = '0;
    mask = '0;
    big  = ({1'b0, b} >= P_WIDE);
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r.s  = wide[P-1:0];
        r.c  = wide[P];
        r.v  = (a[P-1] == b[P-1]) && (r.s[P-1] != a[P-1]);
      end
      OP_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        r.s  = wide[P-1:0];
        r.c  = wide[P];
        r.v  = (a[P-1] != b[P-1]) && (r.s[P-1] != a[P-1]);
      end
      OP_SHR: begin
        if (b == '0) begin
          r.s = a;
        end else if (!big) begin
          r.s  = a >> b;
          mask = LSB_ONE << (b - LSB_ONE);
          r.c  = |(a & mask);
        end
      end
      OP_SHL: begin
        if (b == '0) begin
          r.s = a;
        end else if (!big) begin
          r.s  = a << b;
          mask = MSB_ONE >> (b - LSB_ONE);
          r.c  = |(a & mask);
        end
      end
      OP_AND: r.s = a & b;
      OP_OR:  r.s = a | b;
      OP_XOR: r.s = a ^ b;
`ifdef ALU_SEQ_SRA_EN
      OP_SRA: begin
        if (b == '0) begin
          r.s = a;
        end else if (big) begin
          r.s = {P{a[P-1]}};
        end else begin
          r.s  = $signed(a) >>> b;
          mask = LSB_ONE << (b - LSB_ONE);
          r.c  = |(a & mask);
        end
      end
`endif
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  // One step of the shift-add multiplier and of the restoring divider.
  always_comb begin
    mul_sum      = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, a_reg} : '0);
    mul_hi_next  = mul_sum[P:1];
    mul_lo_next  = {mul_sum[0], mul_lo[P-1:1]};
    div_shift    = {div_rem, div_q[P-1]};
    div_rem_next = div_shift[P-1:0];
    div_q_next   = {div_q[P-2:0], 1'b0};
    if (div_shift >= {1'b0, b_reg}) begin
      div_rem_next = div_shift[P-1:0] - b_reg;
      div_q_next   = {div_q[P-2:0], 1'b1};
    end
  end

  // Final result of the iterative ops, taken from the last step's next values.
  always_comb begin
    exec_res = '0;
    case (op_reg)
      OP_MUL: begin
        exec_res.s = mul_lo_next;
        exec_res.c = |mul_hi_next;
        exec_res.v = |mul_hi_next;
      end
      OP_DIV: begin
        if (b_reg == '0) begin
          exec_res.s = '1;
          exec_res.v = 1'b1;
        end else begin
          exec_res.s = div_q_next;
        end
      end
      OP_MOD: begin
        if (b_reg == '0) begin
          exec_res.s = a_reg;
          exec_res.v = 1'b1;
        end else begin
          exec_res.s = div_rem_next;
        end
      end
      default: exec_res = '0;
    endcase
  end

  // Handshake decode and selection of what gets loaded into the output registers.
  always_comb begin
    accept     = (state == IDLE) && bus.in_valid;
    is_iter    = (bus.OP == OP_MUL) || (bus.OP == OP_DIV) || (bus.OP == OP_MOD);
    iter_done  = (state == EXEC) && (cnt == LAST);
    load_out   = (accept && !is_iter) || iter_done;
    single_res = single_op(bus.A, bus.B, bus.OP);
    out_next   = iter_done ? exec_res : single_res;
  end

  // Control FSM, captured operands and iterative unit state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      op_reg  <= '0;
      mul_hi  <= '0;
      mul_lo  <= '0;
      div_rem <= '0;
      div_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg  <= bus.A;
            b_reg  <= bus.B;
            op_reg <= bus.OP;
            if (is_iter) begin
              state   <= EXEC;
              cnt     <= '0;
              mul_hi  <= '0;
              mul_lo  <= bus.B;
              div_rem <= '0;
              div_q   <= bus.A;
            end else begin
              state <= DONE;
            end
          end
        end
        EXEC: begin
          mul_hi  <= mul_hi_next;
          mul_lo  <= mul_lo_next;
          div_rem <= div_rem_next;
          div_q   <= div_q_next;
          cnt     <= cnt + CNT_ONE;
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result and flag registers, updated only when an operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg   <= '0;
      n_reg   <= 1'b0;
      z_reg   <= 1'b0;
      c_reg   <= 1'b0;
      v_reg   <= 1'b0;
      err_reg <= 1'b0;
    end else if (load_out) begin
      s_reg   <= out_next.s;
      n_reg   <= out_next.s[P-1];
      z_reg   <= (out_next.s == '0);
      c_reg   <= out_next.c;
      v_reg   <= out_next.v;
      err_reg <= out_next.err;
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_reg;
  assign bus.N         = n_reg;
  assign bus.Z         = z_reg;
  assign bus.C         = c_reg;
  assign bus.V         = v_reg;
  assign bus.ERR       = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an arithmetic
// reference model, including latency, backpressure, reset and opcode decode.
module tb_alu_seq;
  localparam int P = 4;
  localparam int W = 1 << P;

  typedef struct packed {
    logic [P-1:0] s;
    logic         n;
    logic         z;
    logic         c;
    logic         v;
    logic         err;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  alu_seq_if #(.P(P)) bus();

  alu_seq #(.P(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: observed no completion, expected $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model from the arithmetic definitions of each operation.
  function automatic res_t model(input int a, input int b, input int op);
    res_t e;
    int   sa, sb, r, s, c, v, err;
    s = 0; c = 0; v = 0; err = 0;
    sa = (a >= W / 2) ? a - W : a;
    sb = (b >= W / 2) ? b - W : b;
    case (op)
      0: begin r = a + b; s = r % W; c = (r >= W); r = sa + sb; v = (r >= W / 2 || r < -W / 2); end
      1: begin s = (a - b + W) % W; c = (a < b); r = sa - sb; v = (r >= W / 2 || r < -W / 2); end
      2: begin
        if (b == 0) s = a;
        else if (b < P) begin s = a >> b; c = (a >> (b - 1)) & 1; end
      end
      3: begin
        if (b == 0) s = a;
        else if (b < P) begin s = (a << b) % W; c = (a >> (P - b)) & 1; end
      end
      4: s = a & b;
      5: s = a | b;
      6: s = a ^ b;
      7: begin r = a * b; s = r % W; c = (r >= W); v = c; end
      8: begin if (b == 0) begin s = W - 1; v = 1; end else s = a / b; end
      9: begin if (b == 0) begin s = a; v = 1; end else s = a % b; end
`ifdef ALU_SEQ_SRA_EN
      10: begin
        if (b == 0) s = a;
        else if (b >= P) s = (sa < 0) ? W - 1 : 0;
        else begin r = sa >>> b; s = r & (W - 1); c = (sa >>> (b - 1)) & 1; end
      end
`endif
      default: err = 1;
    endcase
    e.s   = s[P-1:0];
    e.n   = (s >= W / 2);
    e.z   = (s == 0);
    e.c   = c[0];
    e.v   = v[0];
    e.err = err[0];
    return e;
  endfunction

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input res_t e);
    checkValue({tag, ".S"}, 32'(bus.S), 32'(e.s));
    checkValue({tag, ".N"}, 32'(bus.N), 32'(e.n));
    checkValue({tag, ".Z"}, 32'(bus.Z), 32'(e.z));
    checkValue({tag, ".C"}, 32'(bus.C), 32'(e.c));
    checkValue({tag, ".V"}, 32'(bus.V), 32'(e.v));
    checkValue({tag, ".ERR"}, 32'(bus.ERR), 32'(e.err));
  endtask

  // Presents one operation, scrambles the inputs after acceptance and waits for
  // out_valid, checking the accept-to-valid latency. Starts and ends at a negedge.
  task automatic applyStimulus(input logic [P-1:0] a, input logic [P-1:0] b, input logic [3:0] op);
    int waited = 0;
    int lat = 0;
    int exp_lat;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkValue($sformatf("in_ready op%0d", op), 32'(bus.in_ready), 32'd1);
    bus.A = a; bus.B = b; bus.OP = op; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = P'($urandom); bus.B = P'($urandom); bus.OP = 4'($urandom);
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
    exp_lat = (op >= 7 && op <= 9) ? P + 1 : 1;
    checkValue($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
  endtask

  // Hands the result to the consumer; in_ready must be back the following cycle.
  task automatic handoff();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkValue("handoff.out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("handoff.in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic runOp(input logic [P-1:0] a, input logic [P-1:0] b, input logic [3:0] op);
    applyStimulus(a, b, op);
    checkOutput($sformatf("op%0d a%0h b%0h", op, a, b), model(int'(a), int'(b), int'(op)));
    handoff();
  endtask

  initial begin
    res_t e;
    logic seen_valid;
    logic [P-1:0] ra, rb;
    logic [3:0] rop;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.OP = '0;
    repeat (3) @(negedge clk);
    checkValue("reset.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset", '0);
    rst_n = 1'b1;
    @(negedge clk);
    checkValue("reset_release.in_ready", 32'(bus.in_ready), 32'd1);

    // Test plan vectors, with spot checks of held results against literal values.
    runOp(4'b0010, 4'b1010, 4'd0);
    checkValue("plan add S", 32'(bus.S), 32'b1100);
    runOp(4'b1111, 4'b0110, 4'd0);
    checkValue("plan add C", 32'(bus.C), 32'd1);
    runOp(4'b0010, 4'b1010, 4'd1);
    checkValue("plan sub V", 32'(bus.V), 32'd1);
    runOp(4'b1111, 4'b1011, 4'd1);
    runOp(4'b1010, 4'b0001, 4'd2);
    runOp(4'b1010, 4'b0001, 4'd3);
    checkValue("plan shl S", 32'(bus.S), 32'b0100);
    runOp(4'b0010, 4'b0111, 4'd7);
    checkValue("plan mul S", 32'(bus.S), 32'b1110);
    runOp(4'b0100, 4'b0100, 4'd7);
    checkValue("plan mul C", 32'(bus.C), 32'd1);
    runOp(4'b1100, 4'b0010, 4'd8);
    checkValue("plan div S", 32'(bus.S), 32'b0110);
    runOp(4'b1101, 4'b0100, 4'd9);
    runOp(4'b0101, 4'b0000, 4'd8);
    checkValue("plan div0 S", 32'(bus.S), 32'b1111);
    runOp(4'b0101, 4'b0000, 4'd9);
    runOp(4'b0110, 4'b0011, 4'd11);
    checkValue("plan illegal ERR", 32'(bus.ERR), 32'd1);
    runOp(4'b1010, 4'b0001, 4'd10);

    // Shift boundaries and logic ops.
    runOp(4'b1010, 4'b0000, 4'd2);
    runOp(4'b1011, 4'b0100, 4'd2);
    runOp(4'b1001, 4'b0011, 4'd3);
    runOp(4'b1001, 4'b1111, 4'd3);
    runOp(4'b1001, 4'b0100, 4'd10);
    runOp(4'b0110, 4'b0011, 4'd10);
    runOp(4'b1100, 4'b1010, 4'd4);
    runOp(4'b1100, 4'b1010, 4'd5);
    runOp(4'b1100, 4'b1010, 4'd6);
    runOp(4'b1111, 4'b1111, 4'd7);

    // Backpressure: result held, no capture while out_ready is low.
    applyStimulus(4'b0111, 4'b0001, 4'd0);
    e = model(7, 1, 0);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.A = P'($urandom); bus.B = P'($urandom); bus.OP = 4'($urandom);
      @(negedge clk);
      checkValue("bp.in_ready", 32'(bus.in_ready), 32'd0);
      checkValue("bp.out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp", e);
    end
    bus.in_valid = 1'b0;
    handoff();
    @(negedge clk);
    checkValue("bp.no_capture", 32'(bus.out_valid), 32'd0);

    // Reset in the second EXEC cycle of a MUL, after a result with nonzero flags.
    runOp(4'b0101, 4'b0000, 4'd8);
    bus.A = 4'b0011; bus.B = 4'b0101; bus.OP = 4'd7; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkValue("rst_mid.out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_mid", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkValue("rst_mid.in_ready", 32'(bus.in_ready), 32'd1);
    seen_valid = 1'b0;
    repeat (P + 3) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    checkValue("rst_mid.no_result", 32'(seen_valid), 32'd0);

    // Randomized operations, with divide-by-zero and large shifts favoured.
    for (int i = 0; i < 60; i++) begin
      ra  = P'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? '0 : P'($urandom);
      rop = 4'($urandom_range(0, 15));
      runOp(ra, rb, rop);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
